mem_port_arbiter: RTL and testbench

//  Two-master arbiter for the single-port data/instruction RAM. Port 0 is the CPU memory port
//  (mem_cmd/mem_addr/write_data); port 1 is a secondary master (DMA/debug loader).

---
 rtl/mem_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for a single-port synchronous RAM.
// Port 0 is the CPU memory port and port 1 is a secondary master (DMA or debug loader).
// Ownership is granted per burst. A round-robin tie-break and a beat cap keep either
// master from starving the other. Each read return is tagged so that the data goes back
// to the master that issued the read, even when ownership changes in the same cycle.
//
// Handshake: a master requests while its cmd is READ (01) or WRITE (10). It holds
// cmd/addr/wdata stable until it samples its ack high. ack is combinational: an ack in
// cycle N means the beat is consumed at the rising edge that ends cycle N. For a read,
// rvalid/rdata appear on the issuing port in cycle N+1. For a write, the RAM is written
// at that same edge. Command 11 counts as NONE.
module mem_port_arbiter #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        m0_cmd,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic [1:0]        m1_cmd,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              ram_re,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        owner
);

    // A beat counter needs at least one bit, even when MAX_BURST is 1.
    localparam int BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    // State encoding equals the owner debug encoding, so owner is the raw state register.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                last_q, last_d;   // port that most recently gave up ownership
    logic                rv_q;             // read issued last cycle
    logic                rtag_q;           // which port issued that read

    logic                req0, req1;
    logic                own_req, oth_req, cur_idx;
    state_t              oth_state;
    logic [1:0]          sel_cmd;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                access;

    assign req0 = (m0_cmd == CMD_READ) || (m0_cmd == CMD_WRITE);
    assign req1 = (m1_cmd == CMD_READ) || (m1_cmd == CMD_WRITE);

    // Owner-relative view so that OWN0 and OWN1 can share one transition rule.
    assign cur_idx   = (state_q == OWN1);
    assign own_req   = cur_idx ? req1 : req0;
    assign oth_req   = cur_idx ? req0 : req1;
    assign oth_state = cur_idx ? OWN0 : OWN1;

    // State, beat counter and round-robin memory.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            last_q  <= 1'b1;   // port 0 wins the first tie after reset
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
        end
    end

    // Next-state: grant from IDLE, end a burst on release or on the beat cap.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                beat_d = '0;
                if (req0 && (!req1 || last_q)) begin
                    state_d = OWN0;
                end else if (req1) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (!own_req) begin
                    // Owner released: hand over directly if the other port waits.
                    beat_d  = '0;
                    last_d  = cur_idx;
                    state_d = oth_req ? oth_state : IDLE;
                end else if (beat_q == BEAT_LAST) begin
                    // Cap reached: yield with no bubble, or start a fresh burst if unopposed.
                    beat_d = '0;
                    if (oth_req) begin
                        state_d = oth_state;
                        last_d  = cur_idx;
                    end
                end else begin
                    beat_d = beat_q + BEAT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Route the owning port onto the RAM. IDLE makes no access.
    always_comb begin
        sel_cmd   = 2'b00;
        sel_addr  = '0;
        sel_wdata = '0;
        case (state_q)
            OWN0: begin
                sel_cmd   = m0_cmd;
                sel_addr  = m0_addr;
                sel_wdata = m0_wdata;
            end
            OWN1: begin
                sel_cmd   = m1_cmd;
                sel_addr  = m1_addr;
                sel_wdata = m1_wdata;
            end
            default: begin
                sel_cmd   = 2'b00;
                sel_addr  = '0;
                sel_wdata = '0;
            end
        endcase
    end

    assign ram_re    = (sel_cmd == CMD_READ);
    assign ram_we    = (sel_cmd == CMD_WRITE);
    assign access    = ram_re | ram_we;
    assign ram_addr  = access ? sel_addr  : '0;
    assign ram_wdata = access ? sel_wdata : '0;

    assign m0_ack = (state_q == OWN0) && access;
    assign m1_ack = (state_q == OWN1) && access;

    // Read return tag. It is captured from the state at the read edge, so a
    // simultaneous ownership switch cannot redirect the data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rv_q   <= 1'b0;
            rtag_q <= 1'b0;
        end else begin
            rv_q   <= ram_re;
            rtag_q <= (state_q == OWN1);
        end
    end

    assign m0_rvalid = rv_q && !rtag_q;
    assign m1_rvalid = rv_q &&  rtag_q;
    assign m0_rdata  = m0_rvalid ? ram_rdata : '0;
    assign m1_rdata  = m1_rvalid ? ram_rdata : '0;

    assign owner = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. Directed scenarios cover reset, a single read,
// contention with burst caps, write-then-read, yielding, and the 11 command.
// Expected ack order and read data are queued at issue time, and a negedge monitor
// consumes them whenever the DUT presents an ack or an rvalid.
module tb_mem_port_arbiter;
    localparam int AW = 9;
    localparam int DW = 16;
    localparam logic [1:0] RD = 2'b01;
    localparam logic [1:0] WR = 2'b10;

    // ---------------- clock / reset / signals ----------------
    logic clk = 1'b0;
    logic reset;
    logic [1:0]    m0_cmd, m1_cmd;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_ack, m1_ack, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          ram_re, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic [1:0]    owner;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .owner(owner)
    );

    // Synchronous RAM. Preload gives mem[a] = 0xC000 | a, except mem[0x010] = 0xBEEF.
    logic          preload;
    logic [DW-1:0] mem [0:511];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 512; i++) mem[i] <= 16'hC000 | 16'(i);
            mem[9'h010] <= 16'hBEEF;
            ram_rdata   <= '0;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            if (ram_re) ram_rdata <= mem[ram_addr];
        end
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [1:0]    exp_ack_q[$];          // {m1_ack, m0_ack} expected per ack
    logic [DW-1:0] exp0_q[$], exp1_q[$];  // read data per port
    int            cyc0_q[$], cyc1_q[$];  // cycle each read return is due

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT shows an ack or an rvalid.
    always @(negedge clk) begin
        if (m0_ack || m1_ack) begin
            if (exp_ack_q.size() == 0) check("ack_unexpected", 32'({m1_ack, m0_ack}), 0);
            else check("ack_port", 32'({m1_ack, m0_ack}), 32'(exp_ack_q.pop_front()));
        end
        if (m0_rvalid) begin
            if (exp0_q.size() == 0) check("m0_rvalid_unexpected", 32'(m0_rvalid), 0);
            else begin
                check("m0_rdata", 32'(m0_rdata), 32'(exp0_q.pop_front()));
                check("m0_rlatency", cyc, cyc0_q.pop_front());
            end
        end else check("m0_rdata_idle", 32'(m0_rdata), 0);
        if (m1_rvalid) begin
            if (exp1_q.size() == 0) check("m1_rvalid_unexpected", 32'(m1_rvalid), 0);
            else begin
                check("m1_rdata", 32'(m1_rdata), 32'(exp1_q.pop_front()));
                check("m1_rlatency", cyc, cyc1_q.pop_front());
            end
        end else check("m1_rdata_idle", 32'(m1_rdata), 0);
    end

    // ---------------- driver tasks ----------------
    // Present one beat on port p, hold it until ack, queue the read return, then release.
    task automatic drive(input int p, input logic [1:0] cmd, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [DW-1:0] exp, output int ack_cyc);
        bit got = 0;
        int n = 0;
        ack_cyc = -1;
        if (p == 0) begin m0_cmd = cmd; m0_addr = addr; m0_wdata = wd; end
        else        begin m1_cmd = cmd; m1_addr = addr; m1_wdata = wd; end
        while (!got && n < 40) begin
            @(negedge clk);
            if ((p == 0 && m0_ack) || (p == 1 && m1_ack)) begin
                got = 1;
                ack_cyc = cyc;
            end else n++;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL ack_timeout port%0d: got no ack want ack within 40 cycles", p);
        end else if (cmd == RD) begin
            if (p == 0) begin exp0_q.push_back(exp); cyc0_q.push_back(ack_cyc + 1); end
            else        begin exp1_q.push_back(exp); cyc1_q.push_back(ack_cyc + 1); end
        end
        @(posedge clk);
        #1;
        if (p == 0) begin m0_cmd = 2'b00; m0_addr = '0; m0_wdata = '0; end
        else        begin m1_cmd = 2'b00; m1_addr = '0; m1_wdata = '0; end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    int c0, c1, t0, t1, t6_viol;
    int a0[8];
    int a1[4];

    initial begin
        reset = 1'b0; preload = 1'b1;
        m0_cmd = '0; m0_addr = '0; m0_wdata = '0;
        m1_cmd = '0; m1_addr = '0; m1_wdata = '0;
        repeat (2) @(posedge clk);
        #1 preload = 1'b0;
        @(negedge clk);
        check("rst_owner", 32'(owner), 0);
        check("rst_ram_re", 32'(ram_re), 0);

        // T1: reset asserted mid-burst with a read in flight
        @(posedge clk); #1 reset = 1'b1;
        exp_ack_q.push_back(2'b01);
        m0_cmd = RD; m0_addr = 9'h001;
        @(posedge clk);
        @(negedge clk);
        check("t1_pre_ack", 32'(m0_ack), 1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("t1_rst_owner", 32'(owner), 0);
        check("t1_rst_m0_ack", 32'(m0_ack), 0);
        check("t1_rst_m1_ack", 32'(m1_ack), 0);
        check("t1_rst_m0_rvalid", 32'(m0_rvalid), 0);
        check("t1_rst_m1_rvalid", 32'(m1_rvalid), 0);
        check("t1_rst_ram_re", 32'(ram_re), 0);
        check("t1_rst_ram_we", 32'(ram_we), 0);
        m0_cmd = '0; m0_addr = '0;
        @(posedge clk); #1;
        exp_ack_q.push_back(2'b01);
        exp_ack_q.push_back(2'b10);
        fork
            drive(0, RD, 9'h005, '0, 16'hC005, c0);
            drive(1, RD, 9'h006, '0, 16'hC006, c1);
            begin
                @(posedge clk); #1 reset = 1'b1;
                @(negedge clk); check("t1_cyc0_owner", 32'(owner), 0);
                @(negedge clk); check("t1_cyc1_owner", 32'(owner), 32'h1);
            end
        join
        idle(2);

        // T3: contention, both stream reads with a cap of 4 beats
        repeat (4) exp_ack_q.push_back(2'b01);
        repeat (4) exp_ack_q.push_back(2'b10);
        repeat (4) exp_ack_q.push_back(2'b01);
        fork
            for (int i = 0; i < 8; i++) begin
                drive(0, RD, 9'h020 + 9'(i), '0, 16'hC020 + 16'(i), t0);
                a0[i] = t0;
            end
            for (int j = 0; j < 4; j++) begin
                drive(1, RD, 9'h030 + 9'(j), '0, 16'hC030 + 16'(j), t1);
                a1[j] = t1;
            end
        join
        check("t3_m0_burst", a0[3], a0[0] + 3);
        check("t3_switch_0to1", a1[0], a0[3] + 1);
        check("t3_switch_1to0", a0[4], a1[3] + 1);
        check("t3_m0_burst2", a0[7], a0[4] + 3);
        idle(2);

        // T2: single read from IDLE
        exp_ack_q.push_back(2'b01);
        fork
            drive(0, RD, 9'h010, '0, 16'hBEEF, c0);
            begin
                @(negedge clk); check("t2_cyc0_ack", 32'(m0_ack), 0);
                @(negedge clk); check("t2_cyc1_ack", 32'(m0_ack), 1);
                @(negedge clk);
                check("t2_cyc2_rvalid", 32'(m0_rvalid), 1);
                check("t2_cyc2_rdata", 32'(m0_rdata), 32'hBEEF);
                check("t2_m1_rvalid", 32'(m1_rvalid), 0);
            end
        join
        idle(2);

        // T4: write then read at the top address, back to back
        exp_ack_q.push_back(2'b10);
        exp_ack_q.push_back(2'b10);
        drive(1, WR, 9'h1FF, 16'h1234, '0, c0);
        drive(1, RD, 9'h1FF, '0, 16'h1234, c1);
        check("t4_back_to_back", c1, c0 + 1);
        idle(2);

        // T5: yield to IDLE, lone grant, then the tie goes to port 0
        exp_ack_q.push_back(2'b01);
        drive(0, RD, 9'h040, '0, 16'hC040, c0);
        @(negedge clk); check("t5_release_owner", 32'(owner), 32'h1);
        @(posedge clk); #1;
        check("t5_idle_owner", 32'(owner), 0);
        exp_ack_q.push_back(2'b10);
        fork
            drive(1, RD, 9'h041, '0, 16'hC041, c1);
            begin
                @(negedge clk); check("t5_m1_cyc0_owner", 32'(owner), 0);
                @(negedge clk); check("t5_m1_cyc1_owner", 32'(owner), 32'h2);
            end
        join
        @(posedge clk); #1;
        check("t5_idle2_owner", 32'(owner), 0);
        exp_ack_q.push_back(2'b01);
        exp_ack_q.push_back(2'b10);
        fork
            drive(0, RD, 9'h042, '0, 16'hC042, c0);
            drive(1, RD, 9'h043, '0, 16'hC043, c1);
            begin
                @(negedge clk);
                @(negedge clk); check("t5_tie_owner", 32'(owner), 32'h1);
            end
        join
        idle(2);

        // T6: command 11 on port 0 is not a request
        m0_cmd = 2'b11; m0_addr = 9'h055; m0_wdata = 16'hDEAD;
        t6_viol = 0;
        exp_ack_q.push_back(2'b10);
        fork
            drive(1, RD, 9'h044, '0, 16'hC044, c1);
            repeat (6) begin
                @(negedge clk);
                if (ram_we || m0_ack) t6_viol++;
            end
        join
        check("t6_no_we_no_m0_ack", t6_viol, 0);
        m0_cmd = '0; m0_addr = '0; m0_wdata = '0;
        idle(3);

        check("left_ack", exp_ack_q.size(), 0);
        check("left_m0_rd", exp0_q.size(), 0);
        check("left_m1_rd", exp1_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1);
    end
endmodule
